multicycle_control_unit: RTL and testbench

Multi-cycle control FSM for the MIPS-subset datapath. It replaces the single-cycle opcode decoder with a per-instruction state sequence: fetch, decode, execute, memory, and write-back. Each cycle it drives the datapath strobes, and it stalls on a memory-ready handshake. Opcodes it does not recognise put it in a sticky trap state, which the decoder it supersedes had no way to report.

---
 rtl/mcu_pkg.sv | 60 ++++++
 rtl/mcu_decode.sv | 50 +++++
 rtl/multicycle_control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: shared constants and types for the multi-cycle control unit.
//   - opcode constants for the supported MIPS subset
//   - 3-bit alu_op codes driven to the datapath ALU control
//   - FSM state enum and decoded instruction-class enum
package mcu_pkg;

    // Opcodes
    localparam logic [5:0] OP_ADD  = 6'b001111;
    localparam logic [5:0] OP_SUB  = 6'b000110;
    localparam logic [5:0] OP_AND  = 6'b000000;
    localparam logic [5:0] OP_OR   = 6'b000001;
    localparam logic [5:0] OP_SLT  = 6'b000111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    // ALU function codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADDI  = 3'b011;
    localparam logic [2:0] ALU_ORI   = 3'b100;
    localparam logic [2:0] ALU_ANDI  = 3'b101;
    localparam logic [2:0] ALU_SLTI  = 3'b110;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LOAD,
        CLS_STORE,
        CLS_IMM,
        CLS_BEQ,
        CLS_BNE,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/mcu_decode.sv
// mcu_decode: combinational opcode lookup.
//   op_code  in   6-bit instruction opcode
//   cls      out  instruction class (CLS_ILLEGAL for unknown opcodes)
//   alu_op   out  ALU code used when the class executes (immediate ops differ)
//   legal    out  1 when the opcode is supported
// BNE_EN = 0 makes opcode BNE decode as illegal.
module mcu_decode
    import mcu_pkg::*;
#(
    parameter bit BNE_EN = 1'b1
) (
    input  logic [5:0]   op_code,
    output instr_class_t cls,
    output logic [2:0]   alu_op,
    output logic         legal
);

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        cls    = CLS_ILLEGAL;
        alu_op = ALU_ADD;
        case (op_code)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                cls    = CLS_R;
                alu_op = ALU_RTYPE;
            end
            OP_LW:   cls = CLS_LOAD;
            OP_SW:   cls = CLS_STORE;
            OP_ADDI: begin cls = CLS_IMM; alu_op = ALU_ADDI; end
            OP_ORI:  begin cls = CLS_IMM; alu_op = ALU_ORI;  end
            OP_ANDI: begin cls = CLS_IMM; alu_op = ALU_ANDI; end
            OP_SLTI: begin cls = CLS_IMM; alu_op = ALU_SLTI; end
            OP_BEQ: begin
                cls    = CLS_BEQ;
                alu_op = ALU_SUB;
            end
            OP_BNE: begin
                if (BNE_EN) begin
                    cls    = CLS_BNE;
                    alu_op = ALU_SUB;
                end
            end
            OP_J:    cls = CLS_JUMP;
            default: cls = CLS_ILLEGAL;
        endcase
        legal = (cls != CLS_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the multi-cycle datapath.
//   clk, rst_n       clock (rising edge), async active-low reset
//   op_code          opcode, sampled only in DECODE
//   mem_ready        memory handshake for FETCH / MEM_RD / MEM_WR
//   pc_write, pc_write_cond, branch_ne, pc_src   PC update controls
//   i_or_d, mem_read, mem_write, ir_write        memory / IR controls
//   reg_dst, mem_to_reg, reg_write               register bank controls
//   alu_src_a, alu_src_b, alu_op                 ALU controls
//   instr_done       one-cycle pulse in the last state of an instruction
//   trap             sticky illegal-opcode flag, cleared only by reset
// MEM_WAIT = 0 treats mem_ready as permanently high.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter bit MEM_WAIT = 1'b1,
    parameter bit BNE_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op_code,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_src,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                trap
);

    state_t       state_q, state_d;
    instr_class_t cls_q;
    logic [2:0]   imm_alu_op_q;

    instr_class_t dec_cls;
    logic [2:0]   dec_alu_op;
    logic         dec_legal;
    logic         mem_rdy;
    logic [2:0]   alu_op3;

    assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

    mcu_decode #(.BNE_EN(BNE_EN)) u_decode (
        .op_code (op_code),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op),
        .legal   (dec_legal)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The class and immediate ALU code are captured in DECODE so later states
    // no longer depend on op_code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q        <= CLS_R;
            imm_alu_op_q <= ALU_ADD;
        end else if (state_q == S_DECODE) begin
            cls_q        <= dec_cls;
            imm_alu_op_q <= dec_alu_op;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op3       = ALU_ADD;
        instr_done    = 1'b0;
        trap          = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;   // PC+4 only once the instruction lands
                alu_src_b = 2'b01;
                if (mem_rdy) state_d = S_DECODE;
            end

            S_DECODE: begin
                alu_src_b = 2'b11;     // precompute branch target into ALUOut
                if (!dec_legal) begin
                    state_d = S_TRAP;
                end else begin
                    case (dec_cls)
                        CLS_R:              state_d = S_EXEC_R;
                        CLS_LOAD,
                        CLS_STORE:          state_d = S_MEM_ADDR;
                        CLS_IMM:            state_d = S_EXEC_I;
                        CLS_BEQ, CLS_BNE:   state_d = S_BRANCH;
                        CLS_JUMP:           state_d = S_JUMP;
                        default:            state_d = S_TRAP;
                    endcase
                end
            end

            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op3   = ALU_RTYPE;
                state_d   = S_WB_R;
            end

            S_WB_R: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op3   = imm_alu_op_q;
                state_d   = S_WB_I;
            end

            S_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (cls_q == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_rdy) state_d = S_WB_MEM;
            end

            S_WB_MEM: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_WR: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_rdy;  // store retires in its handshake cycle
                if (mem_rdy) state_d = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op3       = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                branch_ne     = (cls_q == CLS_BNE);
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end

            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_TRAP: begin
                trap    = 1'b1;
                state_d = S_TRAP;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign alu_op = ALU_OP_W'(alu_op3);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. Three instances share one
// stimulus stream: defaults, BNE_EN=0, and MEM_WAIT=0.
module tb_multicycle_control_unit;
    import mcu_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       trap;
    } out_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [5:0]  op;
        logic        mr;
        out_t        exp;
        logic [63:0] tag;
    } vec_t;

    localparam logic [5:0] X_OP = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_code;
    logic       mem_ready;

    wire [2:0] pc_write_w, pc_write_cond_w, branch_ne_w, i_or_d_w, mem_read_w;
    wire [2:0] mem_write_w, ir_write_w, reg_dst_w, mem_to_reg_w, reg_write_w;
    wire [2:0] alu_src_a_w, instr_done_w, trap_w;
    wire [1:0] pc_src_w    [3];
    wire [1:0] alu_src_b_w [3];
    wire [2:0] alu_op_w    [3];

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    out_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_OP_W(3), .MEM_WAIT(1'b1), .BNE_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .pc_write(pc_write_w[0]), .pc_write_cond(pc_write_cond_w[0]),
        .branch_ne(branch_ne_w[0]), .pc_src(pc_src_w[0]), .i_or_d(i_or_d_w[0]),
        .mem_read(mem_read_w[0]), .mem_write(mem_write_w[0]), .ir_write(ir_write_w[0]),
        .reg_dst(reg_dst_w[0]), .mem_to_reg(mem_to_reg_w[0]), .reg_write(reg_write_w[0]),
        .alu_src_a(alu_src_a_w[0]), .alu_src_b(alu_src_b_w[0]), .alu_op(alu_op_w[0]),
        .instr_done(instr_done_w[0]), .trap(trap_w[0])
    );

    multicycle_control_unit #(.ALU_OP_W(3), .MEM_WAIT(1'b1), .BNE_EN(1'b0)) u_dut_nobne (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .pc_write(pc_write_w[1]), .pc_write_cond(pc_write_cond_w[1]),
        .branch_ne(branch_ne_w[1]), .pc_src(pc_src_w[1]), .i_or_d(i_or_d_w[1]),
        .mem_read(mem_read_w[1]), .mem_write(mem_write_w[1]), .ir_write(ir_write_w[1]),
        .reg_dst(reg_dst_w[1]), .mem_to_reg(mem_to_reg_w[1]), .reg_write(reg_write_w[1]),
        .alu_src_a(alu_src_a_w[1]), .alu_src_b(alu_src_b_w[1]), .alu_op(alu_op_w[1]),
        .instr_done(instr_done_w[1]), .trap(trap_w[1])
    );

    multicycle_control_unit #(.ALU_OP_W(3), .MEM_WAIT(1'b0), .BNE_EN(1'b1)) u_dut_nowait (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_ready(mem_ready),
        .pc_write(pc_write_w[2]), .pc_write_cond(pc_write_cond_w[2]),
        .branch_ne(branch_ne_w[2]), .pc_src(pc_src_w[2]), .i_or_d(i_or_d_w[2]),
        .mem_read(mem_read_w[2]), .mem_write(mem_write_w[2]), .ir_write(ir_write_w[2]),
        .reg_dst(reg_dst_w[2]), .mem_to_reg(mem_to_reg_w[2]), .reg_write(reg_write_w[2]),
        .alu_src_a(alu_src_a_w[2]), .alu_src_b(alu_src_b_w[2]), .alu_op(alu_op_w[2]),
        .instr_done(instr_done_w[2]), .trap(trap_w[2])
    );

    function automatic out_t pick(input int s);
        return {pc_write_w[s], pc_write_cond_w[s], branch_ne_w[s], pc_src_w[s],
                i_or_d_w[s], mem_read_w[s], mem_write_w[s], ir_write_w[s],
                reg_dst_w[s], mem_to_reg_w[s], reg_write_w[s], alu_src_a_w[s],
                alu_src_b_w[s], alu_op_w[s], instr_done_w[s], trap_w[s]};
    endfunction

    // Expected per-state output patterns
    function automatic out_t o_zero();
        out_t o = '0;
        return o;
    endfunction
    function automatic out_t o_fetch(input logic rdy);
        out_t o = '0;
        o.mem_read = 1'b1; o.ir_write = rdy; o.pc_write = rdy; o.alu_src_b = 2'b01;
        return o;
    endfunction
    function automatic out_t o_decode();
        out_t o = '0;
        o.alu_src_b = 2'b11;
        return o;
    endfunction
    function automatic out_t o_exec_r();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 3'b010;
        return o;
    endfunction
    function automatic out_t o_wb_r();
        out_t o = '0;
        o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t o_exec_i(input logic [2:0] aop);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = aop;
        return o;
    endfunction
    function automatic out_t o_wb_i();
        out_t o = '0;
        o.reg_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t o_mem_addr();
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic out_t o_mem_rd();
        out_t o = '0;
        o.i_or_d = 1'b1; o.mem_read = 1'b1;
        return o;
    endfunction
    function automatic out_t o_wb_mem();
        out_t o = '0;
        o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t o_mem_wr(input logic rdy);
        out_t o = '0;
        o.i_or_d = 1'b1; o.mem_write = 1'b1; o.instr_done = rdy;
        return o;
    endfunction
    function automatic out_t o_branch(input logic ne);
        out_t o = '0;
        o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_write_cond = 1'b1;
        o.pc_src = 2'b01; o.branch_ne = ne; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t o_jump();
        out_t o = '0;
        o.pc_write = 1'b1; o.pc_src = 2'b10; o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t o_trap();
        out_t o = '0;
        o.trap = 1'b1;
        return o;
    endfunction

    task automatic check(input logic [63:0] tag, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, push the expected
    // outputs, then pop and compare once the combinational outputs settle.
    task automatic step(input int sel, input logic [5:0] op, input logic mr,
                        input out_t exp, input logic [63:0] tag);
        out_t e;
        @(negedge clk);
        op_code   = op;
        mem_ready = mr;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        check(tag, pick(sel), e);
    endtask

    task automatic add(input logic [1:0] sel, input logic [5:0] op, input logic mr,
                       input out_t exp, input logic [63:0] tag);
        vec_t v;
        v.sel = sel; v.op = op; v.mr = mr; v.exp = exp; v.tag = tag;
        vecs.push_back(v);
    endtask

    initial begin
        // Main instruction stream on the default instance. Non-DECODE cycles
        // drive an illegal opcode, and non-memory cycles toggle mem_ready, to
        // show both are ignored there.
        add(0, X_OP,    1, o_fetch(1),       "add_f");
        add(0, OP_ADD,  0, o_decode(),       "add_d");
        add(0, X_OP,    1, o_exec_r(),       "add_x");
        add(0, X_OP,    0, o_wb_r(),         "add_wb");
        add(0, X_OP,    1, o_fetch(1),       "lw_f");
        add(0, OP_LW,   1, o_decode(),       "lw_d");
        add(0, X_OP,    1, o_mem_addr(),     "lw_ma");
        add(0, X_OP,    0, o_mem_rd(),       "lw_rd0");
        add(0, X_OP,    0, o_mem_rd(),       "lw_rd1");
        add(0, X_OP,    1, o_mem_rd(),       "lw_rd2");
        add(0, X_OP,    0, o_wb_mem(),       "lw_wb");
        add(0, X_OP,    1, o_fetch(1),       "sw_f");
        add(0, OP_SW,   0, o_decode(),       "sw_d");
        add(0, X_OP,    0, o_mem_addr(),     "sw_ma");
        add(0, X_OP,    0, o_mem_wr(0),      "sw_wr0");
        add(0, X_OP,    1, o_mem_wr(1),      "sw_wr1");
        add(0, X_OP,    0, o_fetch(0),       "addi_fw");
        add(0, X_OP,    1, o_fetch(1),       "addi_f");
        add(0, OP_ADDI, 0, o_decode(),       "addi_d");
        add(0, X_OP,    0, o_exec_i(3'b011), "addi_x");
        add(0, X_OP,    0, o_wb_i(),         "addi_wb");
        add(0, X_OP,    1, o_fetch(1),       "ori_f");
        add(0, OP_ORI,  0, o_decode(),       "ori_d");
        add(0, X_OP,    0, o_exec_i(3'b100), "ori_x");
        add(0, X_OP,    0, o_wb_i(),         "ori_wb");
        add(0, X_OP,    1, o_fetch(1),       "andi_f");
        add(0, OP_ANDI, 0, o_decode(),       "andi_d");
        add(0, X_OP,    0, o_exec_i(3'b101), "andi_x");
        add(0, X_OP,    0, o_wb_i(),         "andi_wb");
        add(0, X_OP,    1, o_fetch(1),       "slti_f");
        add(0, OP_SLTI, 0, o_decode(),       "slti_d");
        add(0, X_OP,    0, o_exec_i(3'b110), "slti_x");
        add(0, X_OP,    0, o_wb_i(),         "slti_wb");
        add(0, X_OP,    1, o_fetch(1),       "and_f");
        add(0, OP_AND,  0, o_decode(),       "and_d");
        add(0, X_OP,    0, o_exec_r(),       "and_x");
        add(0, X_OP,    0, o_wb_r(),         "and_wb");
        add(0, X_OP,    1, o_fetch(1),       "beq_f");
        add(0, OP_BEQ,  0, o_decode(),       "beq_d");
        add(0, X_OP,    1, o_branch(0),      "beq_br");
        add(0, X_OP,    1, o_fetch(1),       "bne_f");
        add(0, OP_BNE,  0, o_decode(),       "bne_d");
        add(0, X_OP,    0, o_branch(1),      "bne_br");
        add(0, X_OP,    1, o_fetch(1),       "j_f");
        add(0, OP_J,    0, o_decode(),       "j_d");
        add(0, X_OP,    0, o_jump(),         "j_jmp");
        add(0, X_OP,    1, o_fetch(1),       "ill_f");
        add(0, X_OP,    1, o_decode(),       "ill_d");
        add(0, OP_ADD,  1, o_trap(),         "trap0");
        add(0, OP_J,    0, o_trap(),         "trap1");
        add(0, OP_LW,   1, o_trap(),         "trap2");

        rst_n     = 1'b0;
        op_code   = X_OP;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 3; s++) check("in_rst", pick(s), o_zero());
        rst_n = 1'b1;
        #1;
        check("idle", pick(0), o_zero());

        for (int i = 0; i < vecs.size(); i++)
            step(int'(vecs[i].sel), vecs[i].op, vecs[i].mr, vecs[i].exp, vecs[i].tag);

        // Short reset pulse while trapped: outputs clear at once, then FETCH.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("trap_rst", pick(0), o_zero());
        #2;
        rst_n = 1'b1;
        #1;
        check("trap_idl", pick(0), o_zero());
        step(0, X_OP, 1, o_fetch(1), "post_f");
        step(0, OP_J, 0, o_decode(), "post_d");
        step(0, X_OP, 0, o_jump(),   "post_j");

        // BNE with BNE_EN=0 traps and stays trapped.
        step(1, X_OP,   1, o_fetch(1), "nb_f");
        step(1, OP_BNE, 0, o_decode(), "nb_d");
        for (int i = 0; i < 20; i++) step(1, OP_ADD, 1'(i), o_trap(), "nb_trap");

        // MEM_WAIT=0: SW finishes in 4 cycles with mem_ready tied low.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("nw_rst", pick(2), o_zero());
        #2;
        rst_n = 1'b1;
        step(2, X_OP,  0, o_fetch(1),   "nw_f");
        step(2, OP_SW, 0, o_decode(),   "nw_d");
        step(2, X_OP,  0, o_mem_addr(), "nw_ma");
        step(2, X_OP,  0, o_mem_wr(1),  "nw_wr");
        step(2, X_OP,  0, o_fetch(1),   "nw_next");

        // Reset during a stalled FETCH on the default instance.
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("f_stall", pick(0), o_fetch(0));
        rst_n = 1'b0;
        #1;
        check("midf_rst", pick(0), o_zero());
        @(posedge clk);
        #1;
        check("rst_hold", pick(0), o_zero());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle2", pick(0), o_zero());
        step(0, X_OP, 1, o_fetch(1), "refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound on run time in case the stimulus process ever stalls.
    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
